// File: rtl/fft_stream_pkg.sv
// Shared state encodings and error-flag bit positions for the FFT frame streamer.
package fft_stream_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StPrime  = 2'd1;
  localparam state_t StStream = 2'd2;

  localparam int unsigned ErrW               = 3;
  localparam int unsigned ErrTlastMissing    = 0;
  localparam int unsigned ErrTlastUnexpected = 1;
  localparam int unsigned ErrReqDropped      = 2;

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry skid FIFO with registered head; absorbs one BRAM read of latency under backpressure.
module fft_skid_fifo #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [Width-1:0] rdata,
  output logic [1:0]       count
);

  logic [Width-1:0] mem0_q, mem0_d;
  logic [Width-1:0] mem1_q, mem1_d;
  logic [1:0]       count_q, count_d;

  // Callers never pop when empty nor push into a full FIFO without popping.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) mem0_d = wdata;
          else                 mem1_d = wdata;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          mem0_d  = mem1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            mem0_d = wdata;
          end else begin
            mem0_d = mem1_q;
            mem1_d = wdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem0_q;
  assign count = count_q;

endmodule

// File: rtl/fft_frame_streamer.sv
// Streams one FFT frame from the circular sample BRAM to the core over AXI-stream and writes a
// scaled, saturated window of the returned magnitudes into the histogram BRAM.
module fft_frame_streamer
  import fft_stream_pkg::*;
#(
  parameter int unsigned LOG2_N        = 12,
  parameter int unsigned SAMPLE_W      = 16,
  parameter bit          OFFSET_BINARY = 1'b1,
  parameter int unsigned MAG_W         = 24,
  parameter int unsigned OUT_W         = 16,
  parameter int unsigned MAG_SHIFT     = 0,
  parameter int unsigned LOG2_BINS     = 10,
  parameter int unsigned BIN_BASE      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [LOG2_N-1:0]     fhead,
  output logic [LOG2_N-1:0]     faddr,
  input  logic [SAMPLE_W-1:0]   fdata,
  output logic [2*SAMPLE_W-1:0] frame_tdata,
  output logic                  frame_tvalid,
  input  logic                  frame_tready,
  output logic                  frame_tlast,
  input  logic [MAG_W-1:0]      mag_tdata,
  input  logic [LOG2_N-1:0]     mag_tuser,
  input  logic                  mag_tvalid,
  input  logic                  ev_tlast_missing,
  input  logic                  ev_tlast_unexpected,
  output logic [LOG2_BINS-1:0]  haddr,
  output logic [OUT_W-1:0]      hdata,
  output logic                  hwe,
  output logic                  hist_done,
  output logic                  busy,
  input  logic                  err_clr,
  output logic [ErrW-1:0]       error,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned CntW = LOG2_N + 1;
  localparam int unsigned IdxW = LOG2_N + 1;
  localparam logic [CntW-1:0]  FrameLen = CntW'(2 ** LOG2_N);
  localparam logic [MAG_W-1:0] OutMax   = MAG_W'({OUT_W{1'b1}});

  state_t              state_q, state_d;
  logic [LOG2_N-1:0]   faddr_q, faddr_d;
  logic [CntW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [LOG2_N-1:0]   tx_cnt_q, tx_cnt_d;
  logic                inflight_q;
  logic                pending_q, pending_d;
  logic [LOG2_N-1:0]   pend_head_q, pend_head_d;
  logic [ErrW-1:0]     error_q, error_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic [1:0]          fifo_count;
  logic [2:0]          occ_next;
  logic                active, abort, hs, done, issue, drop, start;
  logic [LOG2_N-1:0]   start_head;

  always_comb begin
    sample = fdata;
    if (OFFSET_BINARY) sample[SAMPLE_W-1] = ~fdata[SAMPLE_W-1];
  end

  assign active       = (state_q != StIdle);
  assign abort        = active && (ev_tlast_missing || ev_tlast_unexpected);
  assign frame_tvalid = (fifo_count != 2'd0);
  assign frame_tlast  = frame_tvalid && (tx_cnt_q == '1);
  assign frame_tdata  = {{SAMPLE_W{1'b0}}, fifo_rdata};
  assign hs           = frame_tvalid && frame_tready;
  assign done         = hs && frame_tlast;
  assign drop         = req && active && pending_q;

  // Only read when the data landing next cycle is guaranteed a free slot whatever the core does.
  assign occ_next = 3'(fifo_count) + 3'(inflight_q) - 3'(hs);
  assign issue    = active && !abort && (rd_cnt_q != FrameLen) && (occ_next <= 3'd1);

  fft_skid_fifo #(
    .Width (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .wdata (sample),
    .pop   (hs),
    .flush (abort),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    faddr_d     = faddr_q;
    rd_cnt_d    = rd_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    pending_d   = pending_q;
    pend_head_d = pend_head_q;
    start       = 1'b0;
    start_head  = fhead;

    if (req && active) begin
      pending_d   = 1'b1;
      pend_head_d = fhead;
    end
    if (issue) begin
      faddr_d  = faddr_q + LOG2_N'(1);
      rd_cnt_d = rd_cnt_q + CntW'(1);
    end
    if (hs) tx_cnt_d = tx_cnt_q + LOG2_N'(1);

    case (state_q)
      StIdle: begin
        if (req) begin
          start = 1'b1;
        end else if (pending_q) begin
          start      = 1'b1;
          start_head = pend_head_q;
        end
      end
      StPrime: state_d = abort ? StIdle : StStream;
      StStream: begin
        if (abort) begin
          state_d = StIdle;
        end else if (done) begin
          // A request arriving with the final handshake is the newest head, so it wins.
          if (req) begin
            start = 1'b1;
          end else if (pending_q) begin
            start      = 1'b1;
            start_head = pend_head_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d   = StPrime;
      faddr_d   = start_head;
      rd_cnt_d  = '0;
      tx_cnt_d  = '0;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    error_d = err_clr ? '0 : error_q;
    error_d[ErrTlastMissing]    = error_d[ErrTlastMissing] | ev_tlast_missing;
    error_d[ErrTlastUnexpected] = error_d[ErrTlastUnexpected] | ev_tlast_unexpected;
    error_d[ErrReqDropped]      = error_d[ErrReqDropped] | drop;
    drop_cnt_d = err_clr ? 8'd0 : drop_cnt_q;
    if (drop && (drop_cnt_d != 8'hFF)) drop_cnt_d = drop_cnt_d + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      faddr_q     <= '0;
      rd_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      inflight_q  <= 1'b0;
      pending_q   <= 1'b0;
      pend_head_q <= '0;
      error_q     <= '0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      faddr_q     <= faddr_d;
      rd_cnt_q    <= rd_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      inflight_q  <= issue;
      pending_q   <= pending_d;
      pend_head_q <= pend_head_d;
      error_q     <= error_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign faddr    = faddr_q;
  assign busy     = active;
  assign error    = error_q;
  assign drop_cnt = drop_cnt_q;

  // Receive path: an underflowing subtraction sets the top idx bit, so one compare bounds both ends.
  logic [IdxW-1:0]      idx;
  logic                 in_range;
  logic [MAG_W-1:0]     mag_shifted;
  logic [LOG2_BINS-1:0] haddr_q;
  logic [OUT_W-1:0]     hdata_q;
  logic                 hwe_q, hist_done_q;

  assign idx         = {1'b0, mag_tuser} - IdxW'(BIN_BASE);
  assign in_range    = mag_tvalid && (idx < IdxW'(2 ** LOG2_BINS));
  assign mag_shifted = mag_tdata >> MAG_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haddr_q     <= '0;
      hdata_q     <= '0;
      hwe_q       <= 1'b0;
      hist_done_q <= 1'b0;
    end else begin
      hwe_q       <= in_range;
      hist_done_q <= in_range && (idx[LOG2_BINS-1:0] == '1);
      if (in_range) begin
        haddr_q <= idx[LOG2_BINS-1:0];
        hdata_q <= (mag_shifted > OutMax) ? {OUT_W{1'b1}} : mag_shifted[OUT_W-1:0];
      end
    end
  end

  assign haddr     = haddr_q;
  assign hdata     = hdata_q;
  assign hwe       = hwe_q;
  assign hist_done = hist_done_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed bench for fft_frame_streamer: 16-sample frames, backpressure, queuing, abort, histogram.
module tb_fft_frame_streamer;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [3:0]  fhead;
  logic [3:0]  faddr;
  logic [15:0] fdata = 16'h0;
  logic [31:0] frame_tdata;
  logic        frame_tvalid, frame_tready, frame_tlast;
  logic [23:0] mag_tdata;
  logic [3:0]  mag_tuser;
  logic        mag_tvalid, ev_tlast_missing, ev_tlast_unexpected;
  logic [1:0]  haddr;
  logic [15:0] hdata;
  logic        hwe, hist_done, busy, err_clr;
  logic [2:0]  error;
  logic [7:0]  drop_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] mem [N];
  logic [31:0] beat_data [$];
  logic        beat_last [$];
  int          beat_cyc [$];
  int          stall_bad;

  fft_frame_streamer #(
    .LOG2_N(4), .SAMPLE_W(16), .OFFSET_BINARY(1'b1), .MAG_W(24), .OUT_W(16),
    .MAG_SHIFT(4), .LOG2_BINS(2), .BIN_BASE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .fhead(fhead), .faddr(faddr), .fdata(fdata),
    .frame_tdata(frame_tdata), .frame_tvalid(frame_tvalid), .frame_tready(frame_tready),
    .frame_tlast(frame_tlast), .mag_tdata(mag_tdata), .mag_tuser(mag_tuser),
    .mag_tvalid(mag_tvalid), .ev_tlast_missing(ev_tlast_missing),
    .ev_tlast_unexpected(ev_tlast_unexpected), .haddr(haddr), .hdata(hdata), .hwe(hwe),
    .hist_done(hist_done), .busy(busy), .err_clr(err_clr), .error(error), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read sample BRAM: data valid the cycle after the address.
  always @(posedge clk) fdata <= mem[faddr];

  // Real part expected for an address; memory holds it offset-binary (MSB set).
  function automatic logic [31:0] exp_beat(input int unsigned addr);
    logic [15:0] r;
    r = 16'((addr % N) * 32'h111);
    return {16'h0000, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [3:0] h);
    req = 1'b1;
    fhead = h;
    tick();
    req = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Records handshakes until tlast or the budget runs out; cycle 0 is the call time.
  task automatic collect(input int unsigned ready_pct, input int budget);
    logic        pv, pr, pl, fin;
    logic [31:0] pd;
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    stall_bad = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0;
    for (int c = 0; c < budget; c++) begin
      frame_tready = ($urandom_range(0, 99) < ready_pct);
      if (pv && !pr && (frame_tvalid !== 1'b1 || frame_tdata !== pd || frame_tlast !== pl))
        stall_bad++;
      pv = frame_tvalid; pr = frame_tready; pd = frame_tdata; pl = frame_tlast;
      if (frame_tvalid && frame_tready) begin
        beat_data.push_back(frame_tdata);
        beat_last.push_back(frame_tlast);
        beat_cyc.push_back(c);
        fin = frame_tlast;
      end
      tick();
      if (fin) break;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({faddr, frame_tdata, frame_tvalid, frame_tlast} !== 38'h0) begin
      tests_failed++;
      $display("FAIL reset_stream: faddr=%0h tdata=%0h tvalid=%0b tlast=%0b, want all 0",
               faddr, frame_tdata, frame_tvalid, frame_tlast);
    end
    tests_run++;
    if ({haddr, hdata, hwe, hist_done} !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset_hist: haddr=%0h hdata=%0h hwe=%0b done=%0b, want all 0",
               haddr, hdata, hwe, hist_done);
    end
    tests_run++;
    if ({busy, error, drop_cnt} !== 12'h0) begin
      tests_failed++;
      $display("FAIL reset_status: busy=%0b error=%0b drop=%0d, want 0", busy, error, drop_cnt);
    end
  endtask

  task automatic test_basic_frame();
    frame_tready = 1'b1;
    pulse_req(4'd14);
    tests_run++;
    if ({busy, faddr, frame_tvalid} !== {1'b1, 4'd14, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_prime: busy=%0b faddr=%0d tvalid=%0b, want 1 14 0",
               busy, faddr, frame_tvalid);
    end
    collect(100, 40);
    tests_run++;
    if (beat_data.size() != 16 || beat_cyc[0] != 2 || beat_cyc[15] != 17) begin
      tests_failed++;
      $display("FAIL basic_timing: beats=%0d, want 16 on cycles 2..17", beat_data.size());
    end
    for (int i = 0; i < beat_data.size() && i < 16; i++) begin
      tests_run++;
      if (beat_data[i] !== exp_beat(14 + i) || beat_last[i] !== (i == 15)) begin
        tests_failed++;
        $display("FAIL basic_beat%0d: data=%h last=%0b, want %h %0b",
                 i, beat_data[i], beat_last[i], exp_beat(14 + i), i == 15);
      end
    end
    tests_run++;
    if (busy !== 1'b0 || frame_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_end: busy=%0b tvalid=%0b, want 0 0", busy, frame_tvalid);
    end
  endtask

  task automatic test_backpressure();
    pulse_req(4'd5);
    collect(50, 300);
    tests_run++;
    if (beat_data.size() != 16 || stall_bad != 0) begin
      tests_failed++;
      $display("FAIL bp_frame: beats=%0d unstable=%0d, want 16 0", beat_data.size(), stall_bad);
    end
    for (int i = 0; i < beat_data.size() && i < 16; i++) begin
      tests_run++;
      if (beat_data[i] !== exp_beat(5 + i) || beat_last[i] !== (i == 15)) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: data=%h last=%0b, want %h %0b",
                 i, beat_data[i], beat_last[i], exp_beat(5 + i), i == 15);
      end
    end
    frame_tready = 1'b1;
  endtask

  task automatic test_queue();
    frame_tready = 1'b0;
    pulse_req(4'd3);
    pulse_req(4'd7);
    pulse_req(4'd9);
    tests_run++;
    if ({busy, error, drop_cnt} !== {1'b1, 3'b100, 8'd1}) begin
      tests_failed++;
      $display("FAIL queue_drop: busy=%0b error=%b drop=%0d, want 1 100 1", busy, error, drop_cnt);
    end
    collect(100, 60);
    tests_run++;
    if (beat_data.size() != 16 || beat_data[0] !== exp_beat(3) || beat_data[15] !== exp_beat(2)) begin
      tests_failed++;
      $display("FAIL queue_first_frame: beats=%0d, want 16 from addr 3", beat_data.size());
    end
    tests_run++;
    if (busy !== 1'b1 || faddr !== 4'd9) begin
      tests_failed++;
      $display("FAIL queue_restart: busy=%0b faddr=%0d, want 1 9", busy, faddr);
    end
    collect(100, 40);
    tests_run++;
    if (beat_data.size() != 16 || beat_cyc[0] != 2 || beat_cyc[15] != 17) begin
      tests_failed++;
      $display("FAIL queue_second_timing: beats=%0d, want 16 on cycles 2..17", beat_data.size());
    end
    for (int i = 0; i < beat_data.size() && i < 16; i++) begin
      tests_run++;
      if (beat_data[i] !== exp_beat(9 + i)) begin
        tests_failed++;
        $display("FAIL queue_beat%0d: data=%h, want %h", i, beat_data[i], exp_beat(9 + i));
      end
    end
    pulse_clr();
    tests_run++;
    if (error !== 3'b000 || drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL queue_clear: error=%b drop=%0d, want 000 0", error, drop_cnt);
    end
  endtask

  task automatic test_abort();
    frame_tready = 1'b1;
    pulse_req(4'd0);
    repeat (4) tick();
    tests_run++;
    if (frame_tvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre: tvalid=%0b, want 1", frame_tvalid);
    end
    ev_tlast_missing = 1'b1;
    tick();
    ev_tlast_missing = 1'b0;
    tests_run++;
    if ({frame_tvalid, busy, error} !== {1'b0, 1'b0, 3'b001}) begin
      tests_failed++;
      $display("FAIL abort_state: tvalid=%0b busy=%0b error=%b, want 0 0 001",
               frame_tvalid, busy, error);
    end
    tick();
    tests_run++;
    if (frame_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_flush: tvalid=%0b, want 0", frame_tvalid);
    end
    pulse_clr();
    pulse_req(4'd6);
    collect(100, 40);
    tests_run++;
    if (beat_data.size() != 16 || beat_cyc[0] != 2 || beat_cyc[15] != 17) begin
      tests_failed++;
      $display("FAIL abort_next_timing: beats=%0d, want 16 on cycles 2..17", beat_data.size());
    end
    for (int i = 0; i < beat_data.size() && i < 16; i++) begin
      tests_run++;
      if (beat_data[i] !== exp_beat(6 + i) || beat_last[i] !== (i == 15)) begin
        tests_failed++;
        $display("FAIL abort_beat%0d: data=%h last=%0b, want %h %0b",
                 i, beat_data[i], beat_last[i], exp_beat(6 + i), i == 15);
      end
    end
    ev_tlast_unexpected = 1'b1;
    tick();
    ev_tlast_unexpected = 1'b0;
    tests_run++;
    if (error !== 3'b010 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_event: error=%b busy=%0b, want 010 0", error, busy);
    end
    pulse_clr();
  endtask

  task automatic test_hist();
    logic exp_we;
    mag_tdata = 24'h100000;
    for (int b = 0; b < 8; b++) begin
      mag_tvalid = 1'b1;
      mag_tuser = 4'(b);
      tick();
      exp_we = (b >= 2) && (b < 6);
      tests_run++;
      if (hwe !== exp_we || hist_done !== (b == 5)) begin
        tests_failed++;
        $display("FAIL hist_bin%0d: hwe=%0b done=%0b, want %0b %0b", b, hwe, hist_done,
                 exp_we, b == 5);
      end
      if (exp_we) begin
        tests_run++;
        if (haddr !== 2'(b - 2) || hdata !== 16'hFFFF) begin
          tests_failed++;
          $display("FAIL hist_data%0d: haddr=%0d hdata=%h, want %0d FFFF", b, haddr, hdata, b - 2);
        end
      end
    end
    mag_tuser = 4'd3;
    mag_tdata = 24'h001230;
    tick();
    tests_run++;
    if ({hwe, haddr, hdata, hist_done} !== {1'b1, 2'd1, 16'h0123, 1'b0}) begin
      tests_failed++;
      $display("FAIL hist_scaled: hwe=%0b haddr=%0d hdata=%h done=%0b, want 1 1 0123 0",
               hwe, haddr, hdata, hist_done);
    end
    mag_tvalid = 1'b0;
    mag_tuser = 4'd5;
    tick();
    tests_run++;
    if (hwe !== 1'b0 || hist_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL hist_invalid: hwe=%0b done=%0b, want 0 0", hwe, hist_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    ev_tlast_unexpected = 1'b1;
    tick();
    ev_tlast_unexpected = 1'b0;
    frame_tready = 1'b0;
    pulse_req(4'd4);
    repeat (3) tick();
    tests_run++;
    if (frame_tvalid !== 1'b1 || error !== 3'b010) begin
      tests_failed++;
      $display("FAIL rst_pre: tvalid=%0b error=%b, want 1 010", frame_tvalid, error);
    end
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({faddr, frame_tdata, frame_tvalid, frame_tlast, haddr, hdata, hwe, hist_done, busy,
         error, drop_cnt} !== 70'h0) begin
      tests_failed++;
      $display("FAIL rst_async: faddr=%0d tdata=%h tvalid=%0b busy=%0b error=%b hdata=%h, want 0",
               faddr, frame_tdata, frame_tvalid, busy, error, hdata);
    end
    #2;
    rst_n = 1'b1;
    frame_tready = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (busy !== 1'b0 || frame_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_no_resume: busy=%0b tvalid=%0b, want 0 0", busy, frame_tvalid);
    end
    pulse_req(4'd2);
    collect(100, 40);
    tests_run++;
    if (beat_data.size() != 16 || beat_cyc[0] != 2 || beat_cyc[15] != 17) begin
      tests_failed++;
      $display("FAIL rst_restart_timing: beats=%0d, want 16 on cycles 2..17", beat_data.size());
    end
    for (int i = 0; i < beat_data.size() && i < 16; i++) begin
      tests_run++;
      if (beat_data[i] !== exp_beat(2 + i)) begin
        tests_failed++;
        $display("FAIL rst_beat%0d: data=%h, want %h", i, beat_data[i], exp_beat(2 + i));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < N; a++) mem[a] = 16'h8000 | 16'(a * 32'h111);
    rst_n = 1'b0;
    req = 1'b0;
    fhead = 4'd0;
    frame_tready = 1'b0;
    mag_tdata = 24'h0;
    mag_tuser = 4'd0;
    mag_tvalid = 1'b0;
    ev_tlast_missing = 1'b0;
    ev_tlast_unexpected = 1'b0;
    err_clr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_queue();
    test_abort();
    test_hist();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
